// File: rtl/cal_sequencer.sv
// Calibration sequencer: settles, averages 2^LOG2_SAMPLES samples on the trusted
// and discrete ADC paths, then pulses cal_trig with both averages registered.
module cal_sequencer #(
    parameter int WIDTH          = 16,
    parameter int LOG2_SAMPLES   = 4,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cal_req,
    input  logic [WIDTH-1:0] xadc_scaled,
    input  logic             xadc_valid,
    input  logic [WIDTH-1:0] adc_scaled,
    input  logic             adc_valid,
    output logic [WIDTH-1:0] xadc_avg,
    output logic [WIDTH-1:0] adc_avg,
    output logic             cal_trig,
    output logic             busy,
    output logic             cal_err
);

    localparam int ACC_W = WIDTH + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] N_SAMPLES   = CNT_W'(2 ** LOG2_SAMPLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

    state_t             state_q;
    logic               req_prev_q;
    logic [SET_W-1:0]   settle_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [ACC_W-1:0]   xacc_q;
    logic [ACC_W-1:0]   aacc_q;
    logic [CNT_W-1:0]   xcnt_q;
    logic [CNT_W-1:0]   acnt_q;
    logic [WIDTH-1:0]   xavg_q;
    logic [WIDTH-1:0]   aavg_q;
    logic               trig_q;
    logic               busy_q;
    logic               err_q;

    logic               req_rise;
    logic               x_take;
    logic               a_take;
    logic               both_full;

    assign req_rise  = cal_req & ~req_prev_q;
    // A path stops accepting once it holds N samples; extra valids are dropped.
    assign x_take    = (state_q == ACCUM) && xadc_valid && (xcnt_q != N_SAMPLES);
    assign a_take    = (state_q == ACCUM) && adc_valid && (acnt_q != N_SAMPLES);
    assign both_full = (xcnt_q == N_SAMPLES) && (acnt_q == N_SAMPLES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_prev_q   <= 1'b0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            xacc_q       <= '0;
            aacc_q       <= '0;
            xcnt_q       <= '0;
            acnt_q       <= '0;
            xavg_q       <= '0;
            aavg_q       <= '0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            req_prev_q <= cal_req;
            trig_q     <= 1'b0;

            if (x_take) begin
                xacc_q <= xacc_q + ACC_W'(xadc_scaled);
                xcnt_q <= xcnt_q + CNT_W'(1);
            end
            if (a_take) begin
                aacc_q <= aacc_q + ACC_W'(adc_scaled);
                acnt_q <= acnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (req_rise) begin
                        state_q      <= SETTLE;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        settle_cnt_q <= '0;
                        xacc_q       <= '0;
                        aacc_q       <= '0;
                        xcnt_q       <= '0;
                        acnt_q       <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q   <= ACCUM;
                        tmo_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_W'(1);
                    end
                end
                ACCUM: begin
                    // Completion is checked first so it wins over a same-clock timeout.
                    if (both_full) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        trig_q  <= 1'b1;
                        xavg_q  <= xacc_q[ACC_W-1:LOG2_SAMPLES];
                        aavg_q  <= aacc_q[ACC_W-1:LOG2_SAMPLES];
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign xadc_avg = xavg_q;
    assign adc_avg  = aavg_q;
    assign cal_trig = trig_q;
    assign busy     = busy_q;
    assign cal_err  = err_q;

endmodule

// File: tb/tb_cal_sequencer.sv
// Bench for cal_sequencer: directed sequence with randomized sample data checked
// against arithmetic averages and the settle/timeout clock counts.
module tb_cal_sequencer;

    localparam int WIDTH  = 16;
    localparam int L2     = 2;
    localparam int N      = 4;
    localparam int SETTLE = 8;
    localparam int TMO    = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             cal_req;
    logic [WIDTH-1:0] xadc_scaled;
    logic             xadc_valid;
    logic [WIDTH-1:0] adc_scaled;
    logic             adc_valid;
    logic [WIDTH-1:0] xadc_avg;
    logic [WIDTH-1:0] adc_avg;
    logic             cal_trig;
    logic             busy;
    logic             cal_err;

    int checks   = 0;
    int passes   = 0;
    int fails    = 0;
    int trig_cnt = 0;
    int xv[N];
    int av[N];
    int exp_x = 0;
    int exp_a = 0;

    cal_sequencer #(
        .WIDTH(WIDTH),
        .LOG2_SAMPLES(L2),
        .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cal_req(cal_req),
        .xadc_scaled(xadc_scaled),
        .xadc_valid(xadc_valid),
        .adc_scaled(adc_scaled),
        .adc_valid(adc_valid),
        .xadc_avg(xadc_avg),
        .adc_avg(adc_avg),
        .cal_trig(cal_trig),
        .busy(busy),
        .cal_err(cal_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cal_trig === 1'b1) trig_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller raises cal_req one clock before calling; the first step is the edge that sees it.
    task automatic run_cal(input string tag, input bit junk, input bit gaps, input bit repulse);
        int xi, ai, guard, sx, sa, t0;
        xi = 0; ai = 0; guard = 0; sx = 0; sa = 0;
        t0 = trig_cnt;
        xadc_valid = 1'b0;
        adc_valid  = 1'b0;
        step();
        chk({tag, "_busy_start"}, 32'(busy), 1);
        chk({tag, "_err_cleared"}, 32'(cal_err), 0);
        for (int i = 0; i < SETTLE; i++) begin
            xadc_valid  = junk;
            adc_valid   = junk;
            xadc_scaled = WIDTH'(5000);
            adc_scaled  = WIDTH'(5000);
            step();
        end
        chk({tag, "_accum_busy"}, 32'(busy), 1);
        chk({tag, "_avg_hold"}, 32'(xadc_avg), 32'(exp_x));
        while ((xi < N || ai < N) && guard < 200) begin
            xadc_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            adc_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            xadc_scaled = (xi < N) ? WIDTH'(xv[xi]) : WIDTH'($urandom);
            adc_scaled  = (ai < N) ? WIDTH'(av[ai]) : WIDTH'($urandom);
            if (repulse) cal_req = (guard != 1);
            if (xadc_valid && xi < N) begin
                sx += xv[xi];
                xi++;
            end
            if (adc_valid && ai < N) begin
                sa += av[ai];
                ai++;
            end
            step();
            guard++;
        end
        xadc_valid  = 1'($urandom_range(0, 1));
        adc_valid   = 1'($urandom_range(0, 1));
        xadc_scaled = WIDTH'($urandom);
        adc_scaled  = WIDTH'($urandom);
        if (repulse) cal_req = 1'b1;
        step();
        chk({tag, "_trig"}, 32'(cal_trig), 1);
        chk({tag, "_xavg"}, 32'(xadc_avg), 32'(sx / N));
        chk({tag, "_aavg"}, 32'(adc_avg), 32'(sa / N));
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_err_done"}, 32'(cal_err), 0);
        exp_x = sx / N;
        exp_a = sa / N;
        xadc_valid = 1'b0;
        adc_valid  = 1'b0;
        step();
        chk({tag, "_trig_low"}, 32'(cal_trig), 0);
        chk({tag, "_trig_once"}, 32'(trig_cnt - t0), 1);
        chk({tag, "_xavg_hold"}, 32'(xadc_avg), 32'(exp_x));
    endtask

    initial begin
        int t0;
        reset       = 1'b0;
        cal_req     = 1'b0;
        xadc_valid  = 1'b0;
        adc_valid   = 1'b0;
        xadc_scaled = '0;
        adc_scaled  = '0;

        #2 reset = 1'b1;
        #1;
        chk("rst_xavg", 32'(xadc_avg), 0);
        chk("rst_aavg", 32'(adc_avg), 0);
        chk("rst_trig", 32'(cal_trig), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(cal_err), 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 0);

        xv = '{1000, 1002, 1004, 1006};
        av = '{990, 990, 990, 990};
        cal_req = 1'b1;
        run_cal("nom", 1'b0, 1'b0, 1'b0);
        chk("nom_xavg_1003", 32'(xadc_avg), 1003);
        chk("nom_aavg_990", 32'(adc_avg), 990);

        cal_req = 1'b0; step();
        xv = '{200, 200, 200, 200};
        av = '{200, 200, 200, 200};
        cal_req = 1'b1;
        run_cal("settle", 1'b1, 1'b0, 1'b0);
        chk("settle_xavg_200", 32'(xadc_avg), 200);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                xv[i] = int'($urandom_range(0, 65535));
                av[i] = int'($urandom_range(0, 65535));
            end
            cal_req = 1'b0; step();
            cal_req = 1'b1;
            run_cal("rnd", 1'b0, 1'b1, 1'b0);
        end

        cal_req = 1'b0; step();
        cal_req = 1'b1;
        t0 = trig_cnt;
        step();
        chk("tmo_busy_start", 32'(busy), 1);
        for (int i = 0; i < SETTLE; i++) step();
        for (int i = 0; i < TMO - 1; i++) begin
            xadc_valid = 1'b0;
            adc_valid  = (i < N);
            adc_scaled = WIDTH'($urandom);
            cal_req    = (i != 10);
            step();
        end
        adc_valid = 1'b0;
        chk("tmo_err_early", 32'(cal_err), 0);
        chk("tmo_busy_early", 32'(busy), 1);
        step();
        chk("tmo_err_set", 32'(cal_err), 1);
        chk("tmo_busy_low", 32'(busy), 0);
        chk("tmo_xavg_kept", 32'(xadc_avg), 32'(exp_x));
        chk("tmo_aavg_kept", 32'(adc_avg), 32'(exp_a));
        repeat (3) step();
        chk("tmo_no_trig", 32'(trig_cnt - t0), 0);
        chk("tmo_no_queue", 32'(busy), 0);
        chk("tmo_err_sticky", 32'(cal_err), 1);

        cal_req = 1'b0; step();
        for (int i = 0; i < N; i++) begin
            xv[i] = int'($urandom_range(0, 65535));
            av[i] = int'($urandom_range(0, 65535));
        end
        cal_req = 1'b1;
        t0 = trig_cnt;
        run_cal("hold", 1'b0, 1'b1, 1'b1);
        repeat (470) step();
        chk("hold_one_trig", 32'(trig_cnt - t0), 1);
        chk("hold_no_retrig", 32'(busy), 0);

        cal_req = 1'b0; step();
        xv = '{65535, 65535, 65535, 65535};
        av = '{65535, 65535, 65535, 65535};
        cal_req = 1'b1;
        run_cal("ext", 1'b0, 1'b0, 1'b0);
        chk("ext_xavg_ffff", 32'(xadc_avg), 65535);
        chk("ext_aavg_ffff", 32'(adc_avg), 65535);

        cal_req = 1'b0; step();
        cal_req = 1'b1;
        t0 = trig_cnt;
        step();
        for (int i = 0; i < SETTLE; i++) step();
        xadc_valid  = 1'b1; adc_valid  = 1'b1;
        xadc_scaled = WIDTH'(7); adc_scaled = WIDTH'(9);
        step();
        step();
        chk("abort_busy_accum", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_xavg", 32'(xadc_avg), 0);
        chk("abort_aavg", 32'(adc_avg), 0);
        chk("abort_trig", 32'(cal_trig), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_err", 32'(cal_err), 0);
        exp_x = 0;
        exp_a = 0;
        xadc_valid = 1'b0; adc_valid = 1'b0;
        step();
        step();
        chk("abort_no_trig", 32'(trig_cnt - t0), 0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            xv[i] = int'($urandom_range(0, 65535));
            av[i] = int'($urandom_range(0, 65535));
        end
        run_cal("rel", 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cal_sequencer.md
CAL_SEQUENCER -- requirements
Module: cal_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the sample width in display units (mV).
REQ-002 The block SHALL have parameter LOG2_SAMPLES, default 4, where each path is averaged over N = 2^LOG2_SAMPLES samples.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 1000, the number of clocks ignored after a request before accumulation starts.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum number of clocks allowed in ACCUM.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-007 The block SHALL have port cal_req, input, 1 bit, a synchronous calibration request level where only a rising edge is acted on.
REQ-008 The block SHALL have port xadc_scaled, input, WIDTH bits, the trusted-path sample.
REQ-009 The block SHALL have port xadc_valid, input, 1 bit, which qualifies xadc_scaled for one clock.
REQ-010 The block SHALL have port adc_scaled, input, WIDTH bits, the discrete-ADC sample.
REQ-011 The block SHALL have port adc_valid, input, 1 bit, which qualifies adc_scaled for one clock.
REQ-012 The block SHALL have port xadc_avg, output, WIDTH bits, the averaged trusted value fed to the offset-capture stage.
REQ-013 The block SHALL have port adc_avg, output, WIDTH bits, the averaged discrete value fed to the offset-capture stage.
REQ-014 The block SHALL have port cal_trig, output, 1 bit, a one-clock pulse that captures the offset downstream.
REQ-015 The block SHALL have port busy, output, 1 bit, which is high in SETTLE and ACCUM.
REQ-016 The block SHALL have port cal_err, output, 1 bit, a sticky timeout flag.

Function
REQ-017 The FSM SHALL use exactly the states IDLE, SETTLE, ACCUM and DONE.
REQ-018 In IDLE, a rising edge on cal_req (registered previous value 0, current value 1) SHALL move the FSM to SETTLE on the next clock, clear cal_err, and clear both accumulators and both sample counters.
REQ-019 In IDLE, a held-high cal_req SHALL NOT re-trigger a calibration.
REQ-020 In SETTLE, the FSM SHALL stay for exactly SETTLE_CYCLES clocks and then enter ACCUM.
REQ-021 In SETTLE, valid samples SHALL be ignored.
REQ-022 In ACCUM, each path SHALL independently add its sample to a (WIDTH+LOG2_SAMPLES)-bit unsigned accumulator on every clock its valid is high, until that path's count reaches N.
REQ-023 In ACCUM, samples beyond N on a path SHALL be ignored.
REQ-024 Simultaneous xadc_valid and adc_valid in the same clock SHALL both be accepted.
REQ-025 When both counts equal N, the FSM SHALL enter DONE on the next clock.
REQ-026 In DONE, xadc_avg SHALL equal xadc accumulator >> LOG2_SAMPLES, truncated.
REQ-027 In DONE, adc_avg SHALL equal adc accumulator >> LOG2_SAMPLES, truncated.
REQ-028 In DONE, cal_trig SHALL be 1 for exactly that one clock, with xadc_avg and adc_avg already valid in the same clock.
REQ-029 The FSM SHALL move from DONE to IDLE on the following clock.
REQ-030 xadc_avg and adc_avg SHALL be registered and SHALL hold their values until the next DONE.
REQ-031 The accumulators SHALL never overflow; N samples of 2^WIDTH-1 SHALL average to 2^WIDTH-1.
REQ-032 A timeout counter SHALL run only in ACCUM.
REQ-033 If the timeout counter reaches TIMEOUT_CYCLES before completion, cal_err SHALL be set to 1 and the FSM SHALL return to IDLE.
REQ-034 On a timeout, no cal_trig SHALL be issued and xadc_avg/adc_avg SHALL be unchanged.
REQ-035 If completion and timeout occur in the same clock, completion SHALL take priority.
REQ-036 cal_req edges occurring while busy or in DONE SHALL be ignored and SHALL NOT be queued.
REQ-037 busy SHALL be 1 in SETTLE and ACCUM and 0 in IDLE and DONE.
REQ-038 cal_trig SHALL be 0 in every state other than DONE.

Reset
REQ-039 Asserting reset SHALL immediately set state = IDLE and clear all counters and accumulators.
REQ-040 Asserting reset SHALL immediately drive xadc_avg = 0, adc_avg = 0, cal_trig = 0, busy = 0 and cal_err = 0.
REQ-041 Asserting reset SHALL clear the registered previous value of cal_req to 0.
REQ-042 Reset mid-operation SHALL abort without emitting cal_trig.
REQ-043 cal_req held high through reset release SHALL count as a rising edge.

Verification (WIDTH=16, LOG2_SAMPLES=2, SETTLE_CYCLES=8, TIMEOUT_CYCLES=64)
REQ-044 Reset: assert reset mid-clock -> all outputs 0 immediately, with no clock edge needed.
REQ-045 Nominal: cal_req 0->1, then after settling feed xadc 1000/1002/1004/1006 and adc 990 x4 -> a single cal_trig pulse with xadc_avg=1003, adc_avg=990, busy falling in the DONE clock, and cal_err=0.
REQ-046 Settle masking: valid samples of 5000 during SETTLE, followed by 4x 200 on each path in ACCUM -> both averages=200.
REQ-047 Timeout: after a prior success, supply only adc samples -> cal_err=1 exactly 64 ACCUM clocks after entry, no cal_trig, and averages equal to the prior values.
REQ-048 Request handling: hold cal_req high for 500 clocks, then pulse it again during ACCUM -> exactly one cal_trig.
REQ-049 Extremes and abort: 4x 0xFFFF on both paths -> avg 0xFFFF; a second run with reset asserted in ACCUM -> no cal_trig and all outputs 0.
